// File: rtl/ex_btc_dec_cc_pkg.sv
// Shared definitions for the colour-cell block decoder: FSM states, ENCCC mode
// constants, palette weights and the row/pixel index select helper.
package ex_btc_dec_cc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic MODE_ENCCC1 = 1'b0;
  localparam logic MODE_ENCCC2 = 1'b1;

  localparam logic [7:0] PAL_W_NEAR = 8'd5;
  localparam logic [7:0] PAL_W_FAR  = 8'd3;

  localparam logic [1:0] ROW_LAST = 2'd3;

  typedef logic [3:0][15:0] palette_t;

  // Row r lives in byte 3-r of the index word; ENCCC2 mirrors pixel order.
  function automatic logic [63:0] row_pixels(input logic [31:0] idx, input logic mode,
                                             input logic [1:0] row, input palette_t pal);
    logic [7:0]  row_byte;
    logic [1:0]  sel;
    logic [1:0]  fld;
    logic [63:0] pix;
    row_byte = 8'(idx >> {2'd3 - row, 3'b000});
    pix      = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      sel = (mode == MODE_ENCCC2) ? 2'(3 - p) : 2'(p);
      fld = row_byte[{sel, 1'b0} +: 2];
      pix[16*p +: 16] = pal[fld];
    end
    return pix;
  endfunction

endpackage

// File: rtl/ex_btc_dec_cc_if.sv
// Cell-in / row-out stream bundle for ex_btc_dec_cc.
// master = cell producer plus pixel consumer; slave = the decoder.
interface ex_btc_dec_cc_if;
  logic        blkValid;
  logic        blkReady;
  logic [31:0] blkIdx;
  logic [31:0] blkColors;
  logic        blkMode;
  logic        pixValid;
  logic        pixReady;
  logic [63:0] pixData;
  logic [1:0]  pixRow;
  logic        pixLast;

  modport master (
    output blkValid, blkIdx, blkColors, blkMode, pixReady,
    input  blkReady, pixValid, pixData, pixRow, pixLast
  );

  modport slave (
    input  blkValid, blkIdx, blkColors, blkMode, pixReady,
    output blkReady, pixValid, pixData, pixRow, pixLast
  );
endinterface

// File: rtl/ex_btc_dec_cc_lerp.sv
// Per-channel RGB555 blend: mix = (5*near + 3*far) >> 3, 8-bit intermediate.
module ex_btc_dec_cc_lerp
  import ex_btc_dec_cc_pkg::*;
(
  input  logic [14:0] near_c,
  input  logic [14:0] far_c,
  output logic [14:0] mix_c
);

  logic [7:0] sum;

  always_comb begin
    sum   = '0;
    mix_c = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      sum = PAL_W_NEAR * {3'b000, near_c[5*ch +: 5]} + PAL_W_FAR * {3'b000, far_c[5*ch +: 5]};
      mix_c[5*ch +: 5] = sum[7:3];
    end
  end

endmodule

// File: rtl/ex_btc_dec_cc.sv
// Colour-cell decoder: one 4x4 2bpp cell in, four RGB555 rows out.
// Optional JX2_BTCDEC_ALPHA_EN: min[15] set makes palette entry 0 transparent (16'h8000).
module ex_btc_dec_cc
  import ex_btc_dec_cc_pkg::*;
(
  input logic           clock,
  input logic           reset,
  ex_btc_dec_cc_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [31:0] idx_q, idx_d;
  logic        mode_q, mode_d;
  palette_t    pal_q, pal_d;
  logic [63:0] data_q, data_d;

  palette_t    pal_new;
  logic [14:0] mix_lo;
  logic [14:0] mix_hi;
  logic        blk_ready;
  logic        pix_valid;
  logic        load;
  logic        pix_fire;
  logic        unused_bits;

  ex_btc_dec_cc_lerp u_lerp_lo (
    .near_c (bus.blkColors[30:16]),
    .far_c  (bus.blkColors[14:0]),
    .mix_c  (mix_lo)
  );

  ex_btc_dec_cc_lerp u_lerp_hi (
    .near_c (bus.blkColors[14:0]),
    .far_c  (bus.blkColors[30:16]),
    .mix_c  (mix_hi)
  );

  assign unused_bits = ^{bus.blkColors[31], bus.blkColors[15]};

  always_comb begin
    pal_new[0] = {1'b0, bus.blkColors[30:16]};
`ifdef JX2_BTCDEC_ALPHA_EN
    if (bus.blkColors[31]) pal_new[0] = 16'h8000;
`endif
    pal_new[1] = {1'b0, mix_lo};
    pal_new[2] = {1'b0, mix_hi};
    pal_new[3] = {1'b0, bus.blkColors[14:0]};
  end

  assign pix_valid = (state_q == ST_EMIT);
  assign blk_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_EMIT) && (row_q == ROW_LAST) && bus.pixReady);
  assign load      = bus.blkValid && blk_ready;
  assign pix_fire  = pix_valid && bus.pixReady;

  // A load on the row-3 beat takes priority over returning to IDLE (zero bubble).
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    pal_d   = pal_q;
    data_d  = data_q;
    if (load) begin
      state_d = ST_EMIT;
      row_d   = '0;
      idx_d   = bus.blkIdx;
      mode_d  = bus.blkMode;
      pal_d   = pal_new;
      data_d  = row_pixels(bus.blkIdx, bus.blkMode, 2'd0, pal_new);
    end else if (pix_fire) begin
      if (row_q != ROW_LAST) begin
        row_d  = row_q + 2'd1;
        data_d = row_pixels(idx_q, mode_q, row_q + 2'd1, pal_q);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      mode_q  <= MODE_ENCCC1;
      pal_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      pal_q   <= pal_d;
      data_q  <= data_d;
    end
  end

  assign bus.blkReady = blk_ready;
  assign bus.pixValid = pix_valid;
  assign bus.pixData  = data_q;
  assign bus.pixRow   = row_q;
  assign bus.pixLast  = pix_valid && (row_q == ROW_LAST);

endmodule

// File: tb/tb_ex_btc_dec_cc.sv
// Directed bench for ex_btc_dec_cc with hand-computed RGB555 row values.
module tb_ex_btc_dec_cc;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [63:0] T1_ROW  = 64'h7FFF4E732D6B0000;
  localparam logic [63:0] T2_ROW  = 64'h00002D6B4E737FFF;
  localparam logic [63:0] T7_ROW  = 64'h0E80158B1CF3281F;
  localparam logic [63:0] WHITE4  = 64'h7FFF7FFF7FFF7FFF;
`ifdef JX2_BTCDEC_ALPHA_EN
  localparam logic [63:0] ALPHA0  = 64'h8000800080008000;
`else
  localparam logic [63:0] ALPHA0  = 64'h0000000000000000;
`endif

  logic [63:0] t3_rows [4];
  logic [15:0] stall_pat;
  int          rc;

  ex_btc_dec_cc_if bus ();

  ex_btc_dec_cc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cell(input string tag, input logic [31:0] idx,
                           input logic [31:0] colors, input logic mode);
    int unsigned n = 0;
    bus.blkValid  = 1'b1;
    bus.blkIdx    = idx;
    bus.blkColors = colors;
    bus.blkMode   = mode;
    #1;
    while (bus.blkReady !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_accept_in_time"}, 64'(n < 20), 64'd1);
    tick();
    bus.blkValid = 1'b0;
  endtask

  task automatic expect_row(input string tag, input logic [63:0] exp_data, input int exp_row);
    int unsigned n = 0;
    bus.pixReady = 1'b1;
    #1;
    while (bus.pixValid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid_in_time"}, 64'(n < 20), 64'd1);
    chk({tag, "_data"}, bus.pixData, exp_data);
    chk({tag, "_row"},  64'(bus.pixRow), 64'(exp_row));
    chk({tag, "_last"}, 64'(bus.pixLast), 64'(exp_row == 3));
    tick();
  endtask

  initial begin
    t3_rows[0] = 64'h7FFF7FFF7FFF7FFF;
    t3_rows[1] = 64'h0000000000000000;
    t3_rows[2] = 64'h4E734E734E734E73;
    t3_rows[3] = 64'h2D6B2D6B2D6B2D6B;
    stall_pat  = 16'b1001_0100_1001_0011;

    bus.blkValid  = 1'b0;
    bus.blkIdx    = '0;
    bus.blkColors = '0;
    bus.blkMode   = 1'b0;
    bus.pixReady  = 1'b0;
    reset         = 1'b0;
    #1;
    chk("rst_pix_valid", 64'(bus.pixValid), 64'd0);
    chk("rst_pix_data",  bus.pixData, 64'd0);
    chk("rst_pix_row",   64'(bus.pixRow), 64'd0);
    chk("rst_pix_last",  64'(bus.pixLast), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_blk_ready", 64'(bus.blkReady), 64'd1);

    // 1: full-range gradient, ENCCC1 order
    bus.pixReady = 1'b1;
    send_cell("t1", 32'hE4E4E4E4, 32'h00007FFF, 1'b0);
    for (int r = 0; r < 4; r++) expect_row("t1", T1_ROW, r);
    chk("t1_idle_after", 64'(bus.pixValid), 64'd0);

    // 2: same cell, ENCCC2 order
    send_cell("t2", 32'hE4E4E4E4, 32'h00007FFF, 1'b1);
    for (int r = 0; r < 4; r++) expect_row("t2", T2_ROW, r);

    // 3: min > max, distinct rows
    send_cell("t3", 32'h00FF55AA, 32'h7FFF0000, 1'b0);
    for (int r = 0; r < 4; r++) expect_row("t3", t3_rows[r], r);

    // 7: mixed channels, checks per-channel truncation
    send_cell("t7", 32'hE4E4E4E4, 32'h281F0E80, 1'b0);
    for (int r = 0; r < 4; r++) expect_row("t7", T7_ROW, r);

    // 4: consumer stalls; data must hold and rows advance only on accept
    bus.pixReady = 1'b0;
    send_cell("t4", 32'h00FF55AA, 32'h7FFF0000, 1'b0);
    rc = 0;
    for (int i = 0; i < 16 && rc < 4; i++) begin
      bus.pixReady = stall_pat[i];
      #1;
      chk("t4_valid", 64'(bus.pixValid), 64'd1);
      chk("t4_row",   64'(bus.pixRow), 64'(rc));
      chk("t4_data",  bus.pixData, t3_rows[rc]);
      tick();
      if (stall_pat[i]) rc++;
    end
    chk("t4_all_rows", 64'(rc), 64'd4);
    chk("t4_idle_after", 64'(bus.pixValid), 64'd0);

    // 5: back-to-back cells with no bubble
    bus.pixReady = 1'b1;
    send_cell("t5a", 32'hE4E4E4E4, 32'h00007FFF, 1'b0);
    bus.blkValid  = 1'b1;
    bus.blkIdx    = 32'h00FF55AA;
    bus.blkColors = 32'h7FFF0000;
    bus.blkMode   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_valid", 64'(bus.pixValid), 64'd1);
      chk("t5_row",   64'(bus.pixRow), 64'(i % 4));
      chk("t5_data",  bus.pixData, (i < 4) ? T1_ROW : t3_rows[i-4]);
      chk("t5_blk_ready", 64'(bus.blkReady), 64'((i % 4) == 3));
      tick();
      if (i == 3) bus.blkValid = 1'b0;
    end
    chk("t5_idle_after", 64'(bus.pixValid), 64'd0);

    // 6: reset during row 1 discards the cell
    send_cell("t6", 32'hE4E4E4E4, 32'h00007FFF, 1'b0);
    expect_row("t6_pre", T1_ROW, 0);
    chk("t6_at_row1", 64'(bus.pixRow), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.pixValid), 64'd0);
    chk("t6_rst_data",  bus.pixData, 64'd0);
    chk("t6_rst_row",   64'(bus.pixRow), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t6_blk_ready", 64'(bus.blkReady), 64'd1);
    chk("t6_no_partial", 64'(bus.pixValid), 64'd0);
    send_cell("t6b", 32'hE4E4E4E4, 32'h00007FFF, 1'b1);
    expect_row("t6_next", T2_ROW, 0);
    for (int r = 1; r < 4; r++) expect_row("t6_next", T2_ROW, r);

    // endpoint bit15: transparent marker only with the alpha build
    send_cell("ta", 32'h00FFFFFF, 32'h8000FFFF, 1'b0);
    expect_row("ta", ALPHA0, 0);
    for (int r = 1; r < 4; r++) expect_row("ta", WHITE4, r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
